// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding selectors.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_FILL     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam int PC_IDX  = 15;
   localparam int CNT_W   = 16;
   localparam int STALL_W = 16;

   typedef struct packed {
      logic pc_le;
      logic if_id_le;
      logic pipe_le;
      logic s;
      logic flush;
   } ctrl_t;

   // Control words, fields in order {pc_le, if_id_le, pipe_le, s, flush}.
   localparam ctrl_t CTRL_FILL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID-stage source index; nearest producing stage wins.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_we,
   input  logic             ex_load,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_we,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_we,
   output logic [1:0]       sel
);

   localparam logic [REG_W-1:0] PC_REG = REG_W'(PC_IDX);

   // A load in EX has no data yet, so it never forwards from EX.
   always_comb begin
      sel = FWD_RF;
      if (src != PC_REG) begin
         if (ex_we && !ex_load && (src == ex_rd))
            sel = FWD_EX;
         else if (mem_we && (src == mem_rd))
            sel = FWD_MEM;
         else if (wb_we && (src == wb_rd))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: fill bubbles, load-use stall, branch flush, memory wait
// with timeout halt, and operand forwarding selects.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W    = 4,
   parameter int FILL_CYC = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic               clk,
   input  logic               R,
   input  logic [REG_W-1:0]   ID_rn,
   input  logic [REG_W-1:0]   ID_rm,
   input  logic [REG_W-1:0]   ID_rd,
   input  logic               ID_use_rn,
   input  logic               ID_use_rm,
   input  logic               ID_use_rd,
   input  logic               ID_branch_taken,
   input  logic [REG_W-1:0]   EX_rd,
   input  logic [REG_W-1:0]   MEM_rd,
   input  logic [REG_W-1:0]   WB_rd,
   input  logic               EX_RF_enable,
   input  logic               MEM_RF_enable,
   input  logic               WB_RF_enable,
   input  logic               EX_load_instr,
   input  logic               MEM_Enable_signal,
   input  logic               mem_ready,
   output logic               PC_LE,
   output logic               IF_ID_LE,
   output logic               pipe_LE,
   output logic               S,
   output logic               IF_ID_flush,
   output logic [1:0]         fwd_A,
   output logic [1:0]         fwd_B,
   output logic [1:0]         fwd_C,
   output logic               mem_err,
   output logic [STALL_W-1:0] stall_count,
   output state_t             state_dbg
);

   state_t           state;
   logic [CNT_W-1:0] fill_cnt;
   logic [CNT_W-1:0] wait_cnt;
   logic             load_use;
   logic             mem_stall;
   ctrl_t            run_ctrl;
   ctrl_t            ctrl;

   assign load_use = EX_load_instr && EX_RF_enable &&
                     ((ID_use_rn && (ID_rn == EX_rd)) ||
                      (ID_use_rm && (ID_rm == EX_rd)) ||
                      (ID_use_rd && (ID_rd == EX_rd)));

   assign mem_stall = MEM_Enable_signal && !mem_ready;

   // Normal-flow arbitration: a freeze masks the load-use bubble, a bubble masks the flush.
   always_comb begin
      run_ctrl = CTRL_PASS;
      if (mem_stall)
         run_ctrl = CTRL_FREEZE;
      else if (load_use)
         run_ctrl = CTRL_BUBBLE;
      else if (ID_branch_taken)
         run_ctrl = CTRL_FLUSH;
   end

   always_comb begin
      ctrl = CTRL_FILL;
      case (state)
         ST_FILL:     ctrl = CTRL_FILL;
         ST_RUN:      ctrl = run_ctrl;
         ST_MEM_WAIT: ctrl = mem_ready ? run_ctrl : CTRL_FREEZE;
         ST_HALT:     ctrl = CTRL_HALT;
         default:     ctrl = CTRL_HALT;
      endcase
   end

   assign PC_LE       = ctrl.pc_le;
   assign IF_ID_LE    = ctrl.if_id_le;
   assign pipe_LE     = ctrl.pipe_le;
   assign S           = ctrl.s;
   assign IF_ID_flush = ctrl.flush;
   assign state_dbg   = state;

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state       <= ST_FILL;
         fill_cnt    <= '0;
         wait_cnt    <= '0;
         stall_count <= '0;
         mem_err     <= 1'b0;
      end else begin
         if (((state == ST_RUN) || (state == ST_MEM_WAIT)) && !ctrl.pc_le)
            stall_count <= sat_inc(stall_count);

         case (state)
            ST_FILL: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == CNT_W'(FILL_CYC - 1))
                  state <= ST_RUN;
            end
            ST_RUN: begin
               if (mem_stall) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt >= CNT_W'(TIMEOUT)) begin
                  state   <= ST_HALT;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_HALT: begin
               mem_err <= 1'b1;
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

   fwd_select #(.REG_W(REG_W)) u_fwd_a (
      .src     (ID_rn),
      .ex_rd   (EX_rd),
      .ex_we   (EX_RF_enable),
      .ex_load (EX_load_instr),
      .mem_rd  (MEM_rd),
      .mem_we  (MEM_RF_enable),
      .wb_rd   (WB_rd),
      .wb_we   (WB_RF_enable),
      .sel     (fwd_A)
   );

   fwd_select #(.REG_W(REG_W)) u_fwd_b (
      .src     (ID_rm),
      .ex_rd   (EX_rd),
      .ex_we   (EX_RF_enable),
      .ex_load (EX_load_instr),
      .mem_rd  (MEM_rd),
      .mem_we  (MEM_RF_enable),
      .wb_rd   (WB_rd),
      .wb_we   (WB_RF_enable),
      .sel     (fwd_B)
   );

   fwd_select #(.REG_W(REG_W)) u_fwd_c (
      .src     (ID_rd),
      .ex_rd   (EX_rd),
      .ex_we   (EX_RF_enable),
      .ex_load (EX_load_instr),
      .mem_rd  (MEM_rd),
      .mem_we  (MEM_RF_enable),
      .wb_rd   (WB_rd),
      .wb_we   (WB_RF_enable),
      .sel     (fwd_C)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: inputs change on the falling edge, outputs are checked 2 ns later.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       R;
   logic [3:0] ID_rn, ID_rm, ID_rd, EX_rd, MEM_rd, WB_rd;
   logic       ID_use_rn, ID_use_rm, ID_use_rd, ID_branch_taken;
   logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr;
   logic       MEM_Enable_signal, mem_ready;
   logic       PC_LE, IF_ID_LE, pipe_LE, S, IF_ID_flush, mem_err;
   logic [1:0] fwd_A, fwd_B, fwd_C;
   logic [15:0] stall_count;
   state_t     state_dbg;

   // Control codes {PC_LE, IF_ID_LE, pipe_LE, S, IF_ID_flush}
   localparam logic [4:0] C_FILL  = 5'b11110;
   localparam logic [4:0] C_PASS  = 5'b11100;
   localparam logic [4:0] C_FLUSH = 5'b11101;
   localparam logic [4:0] C_BUB   = 5'b00110;
   localparam logic [4:0] C_FRZ   = 5'b00000;
   localparam logic [4:0] C_HALT  = 5'b00010;

   logic [13:0] obs;
   logic [13:0] exp_v;
   logic [13:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(4), .FILL_CYC(4), .TIMEOUT(15)) dut (
      .clk               (clk),
      .R                 (R),
      .ID_rn             (ID_rn),
      .ID_rm             (ID_rm),
      .ID_rd             (ID_rd),
      .ID_use_rn         (ID_use_rn),
      .ID_use_rm         (ID_use_rm),
      .ID_use_rd         (ID_use_rd),
      .ID_branch_taken   (ID_branch_taken),
      .EX_rd             (EX_rd),
      .MEM_rd            (MEM_rd),
      .WB_rd             (WB_rd),
      .EX_RF_enable      (EX_RF_enable),
      .MEM_RF_enable     (MEM_RF_enable),
      .WB_RF_enable      (WB_RF_enable),
      .EX_load_instr     (EX_load_instr),
      .MEM_Enable_signal (MEM_Enable_signal),
      .mem_ready         (mem_ready),
      .PC_LE             (PC_LE),
      .IF_ID_LE          (IF_ID_LE),
      .pipe_LE           (pipe_LE),
      .S                 (S),
      .IF_ID_flush       (IF_ID_flush),
      .fwd_A             (fwd_A),
      .fwd_B             (fwd_B),
      .fwd_C             (fwd_C),
      .mem_err           (mem_err),
      .stall_count       (stall_count),
      .state_dbg         (state_dbg)
   );

   assign obs = {PC_LE, IF_ID_LE, pipe_LE, S, IF_ID_flush, fwd_A, fwd_B, fwd_C, mem_err, state_dbg};

   function automatic logic [13:0] ev(input logic [4:0] ctl, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c,
                                      input logic err, input state_t st);
      return {ctl, a, b, c, err, st};
   endfunction

   task automatic idle();
      ID_rn = '0; ID_rm = '0; ID_rd = '0;
      ID_use_rn = 1'b0; ID_use_rm = 1'b0; ID_use_rd = 1'b0;
      ID_branch_taken = 1'b0;
      EX_rd = '0; MEM_rd = '0; WB_rd = '0;
      EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
      EX_load_instr = 1'b0; MEM_Enable_signal = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic load_use_stim(input logic [3:0] r);
      EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = r;
      ID_rn = r; ID_use_rn = 1'b1;
   endtask

   task automatic load_in_mem(input logic [3:0] r);
      MEM_rd = r; MEM_RF_enable = 1'b1;
      ID_rn = r; ID_use_rn = 1'b1;
   endtask

   task automatic test_reset();
      R = 1'b1;
      idle();
      @(negedge clk);
      exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
      #2;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs, exp_v);
      end
      checks++;
      if (stall_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall_count: got %0d expected 0", stall_count);
      end
      @(negedge clk);
      R = 1'b0;
      for (int c = 0; c < 6; c++) begin
         idle();
         case (c)
            0: begin
               EX_rd = 4'd1; EX_RF_enable = 1'b1; ID_rn = 4'd1;
               exp_q.push_back(ev(C_FILL, FWD_EX, FWD_RF, FWD_RF, 1'b0, ST_FILL));
            end
            1: begin
               load_use_stim(4'd3);
               exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
            end
            2: begin
               MEM_Enable_signal = 1'b1;
               exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
            end
            3: exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
            default: exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
         endcase
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL fill c%0d: got %b expected %b", c, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load_use();
      for (int c = 0; c < 7; c++) begin
         idle();
         case (c)
            0: begin
               load_use_stim(4'd3);
               exp_q.push_back(ev(C_BUB, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            1: begin
               load_in_mem(4'd3);
               exp_q.push_back(ev(C_PASS, FWD_MEM, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            2: begin
               EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd5;
               ID_rm = 4'd5; ID_use_rm = 1'b1;
               exp_q.push_back(ev(C_BUB, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            3: begin
               MEM_rd = 4'd5; MEM_RF_enable = 1'b1; ID_rm = 4'd5; ID_use_rm = 1'b1;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_MEM, FWD_RF, 1'b0, ST_RUN));
            end
            4: begin
               EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd7; ID_rn = 4'd7;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            5: begin
               EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd9;
               ID_rd = 4'd9; ID_use_rd = 1'b1;
               exp_q.push_back(ev(C_BUB, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            default: begin
               MEM_rd = 4'd9; MEM_RF_enable = 1'b1; ID_rd = 4'd9; ID_use_rd = 1'b1;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_MEM, 1'b0, ST_RUN));
            end
         endcase
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL load_use c%0d: got %b expected %b", c, obs, exp_v);
         end
         if (c == 1) begin
            checks++;
            if (stall_count !== 16'd1) begin
               errors++;
               $display("FAIL load_use_stall1: got %0d expected 1", stall_count);
            end
         end
         if (c == 6) begin
            checks++;
            if (stall_count !== 16'd3) begin
               errors++;
               $display("FAIL load_use_stall3: got %0d expected 3", stall_count);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_forward();
      for (int c = 0; c < 5; c++) begin
         idle();
         case (c)
            0: begin
               EX_rd = 4'd2; EX_RF_enable = 1'b1; MEM_rd = 4'd2; MEM_RF_enable = 1'b1;
               WB_rd = 4'd2; WB_RF_enable = 1'b1;
               ID_rn = 4'd2; ID_rm = 4'd7; ID_rd = 4'd9;
               exp_q.push_back(ev(C_PASS, FWD_EX, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            1: begin
               EX_rd = 4'd15; EX_RF_enable = 1'b1; MEM_rd = 4'd4; MEM_RF_enable = 1'b1;
               WB_rd = 4'd6; WB_RF_enable = 1'b1;
               ID_rn = 4'd15; ID_rm = 4'd4; ID_rd = 4'd6;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_MEM, FWD_WB, 1'b0, ST_RUN));
            end
            2: begin
               EX_rd = 4'd8; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
               WB_rd = 4'd8; WB_RF_enable = 1'b1;
               ID_rn = 4'd8; ID_rm = 4'd8; ID_rd = 4'd0;
               exp_q.push_back(ev(C_PASS, FWD_WB, FWD_WB, FWD_RF, 1'b0, ST_RUN));
            end
            3: begin
               MEM_rd = 4'd15; MEM_RF_enable = 1'b1; WB_rd = 4'd15; WB_RF_enable = 1'b1;
               ID_rn = 4'd15; ID_rm = 4'd15; ID_rd = 4'd15;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            default: begin
               EX_rd = 4'd3; MEM_rd = 4'd3; MEM_RF_enable = 1'b1;
               WB_rd = 4'd3; WB_RF_enable = 1'b1;
               ID_rn = 4'd3; ID_rm = 4'd3; ID_rd = 4'd1;
               exp_q.push_back(ev(C_PASS, FWD_MEM, FWD_MEM, FWD_RF, 1'b0, ST_RUN));
            end
         endcase
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL forward c%0d: got %b expected %b", c, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mem_wait();
      for (int c = 0; c < 8; c++) begin
         idle();
         case (c)
            0: begin
               MEM_Enable_signal = 1'b1;
               exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            1, 2: begin
               MEM_Enable_signal = 1'b1;
               exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_MEM_WAIT));
            end
            3: begin
               MEM_Enable_signal = 1'b1; mem_ready = 1'b1;
               exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_MEM_WAIT));
            end
            4: exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            5: begin
               MEM_Enable_signal = 1'b1; load_use_stim(4'd4);
               exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            6: begin
               MEM_Enable_signal = 1'b1; mem_ready = 1'b1; load_use_stim(4'd4);
               exp_q.push_back(ev(C_BUB, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_MEM_WAIT));
            end
            default: begin
               load_in_mem(4'd4);
               exp_q.push_back(ev(C_PASS, FWD_MEM, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
         endcase
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mem_wait c%0d: got %b expected %b", c, obs, exp_v);
         end
         if (c == 4) begin
            checks++;
            if (stall_count !== 16'd6) begin
               errors++;
               $display("FAIL mem_wait_stall6: got %0d expected 6", stall_count);
            end
         end
         if (c == 7) begin
            checks++;
            if (stall_count !== 16'd8) begin
               errors++;
               $display("FAIL mem_wait_stall8: got %0d expected 8", stall_count);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      for (int c = 0; c < 7; c++) begin
         idle();
         case (c)
            0: begin
               ID_branch_taken = 1'b1;
               exp_q.push_back(ev(C_FLUSH, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            1: begin
               ID_branch_taken = 1'b1; load_use_stim(4'd6);
               exp_q.push_back(ev(C_BUB, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            2: begin
               ID_branch_taken = 1'b1; load_in_mem(4'd6);
               exp_q.push_back(ev(C_FLUSH, FWD_MEM, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            3: exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            4: begin
               ID_branch_taken = 1'b1; MEM_Enable_signal = 1'b1;
               exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
            end
            5: begin
               ID_branch_taken = 1'b1; MEM_Enable_signal = 1'b1; mem_ready = 1'b1;
               exp_q.push_back(ev(C_FLUSH, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_MEM_WAIT));
            end
            default: exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
         endcase
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL branch c%0d: got %b expected %b", c, obs, exp_v);
         end
         if (c == 3) begin
            checks++;
            if (stall_count !== 16'd9) begin
               errors++;
               $display("FAIL branch_stall9: got %0d expected 9", stall_count);
            end
         end
         if (c == 6) begin
            checks++;
            if (stall_count !== 16'd10) begin
               errors++;
               $display("FAIL branch_stall10: got %0d expected 10", stall_count);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      for (int c = 0; c < 20; c++) begin
         idle();
         MEM_Enable_signal = 1'b1;
         mem_ready = (c == 18);
         if (c == 0)
            exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
         else if (c <= 15)
            exp_q.push_back(ev(C_FRZ, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_MEM_WAIT));
         else
            exp_q.push_back(ev(C_HALT, FWD_RF, FWD_RF, FWD_RF, 1'b1, ST_HALT));
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL timeout c%0d: got %b expected %b", c, obs, exp_v);
         end
         @(negedge clk);
      end
      checks++;
      if (stall_count !== 16'd26) begin
         errors++;
         $display("FAIL timeout_stall: got %0d expected 26", stall_count);
      end
      // Reset lands between clock edges; it must take effect before the next rising edge.
      R = 1'b1;
      idle();
      exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
      #2;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL halt_reset: got %b expected %b", obs, exp_v);
      end
      checks++;
      if (stall_count !== 16'd0) begin
         errors++;
         $display("FAIL halt_reset_stall: got %0d expected 0", stall_count);
      end
      @(negedge clk);
      R = 1'b0;
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c < 4)
            exp_q.push_back(ev(C_FILL, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_FILL));
         else
            exp_q.push_back(ev(C_PASS, FWD_RF, FWD_RF, FWD_RF, 1'b0, ST_RUN));
         #2;
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL refill c%0d: got %b expected %b", c, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      R = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_forward();
      test_mem_wait();
      test_branch();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core (PC → IF_ID → ID_EX → EX_MEM → MEM_WB). It drives the PC and IF_ID load enables, the CU_mux bubble select `S`, the IF_ID flush, and a global freeze for the back-end latches. It also produces operand-forwarding selects for the ID-stage operand muxes. A small FSM handles post-reset pipeline fill, data-memory wait states with timeout, and a sticky error halt.

## Interface
- `REG_W`, 4: register-index width
- `FILL_CYC`, 4: bubble cycles issued after reset release
- `TIMEOUT`, 15: maximum consecutive memory-wait cycles before halt
- `clk`  in  1  system clock, rising edge
- `R`  in  1  reset, asynchronous, active-high
- `ID_rn`, `ID_rm`, `ID_rd`  in  REG_W  source register indices of the instruction in ID (`ID_rd` = store-data source)
- `ID_use_rn`, `ID_use_rm`, `ID_use_rd`  in  1  corresponding source actually read
- `ID_branch_taken`  in  1  branch in ID resolved taken
- `EX_rd`, `MEM_rd`, `WB_rd`  in  REG_W  destination index per stage
- `EX_RF_enable`, `MEM_RF_enable`, `WB_RF_enable`  in  1  stage writes RF
- `EX_load_instr`  in  1  EX holds a load
- `MEM_Enable_signal`  in  1  MEM stage accesses data memory
- `mem_ready`  in  1  data memory completes access this cycle
- `PC_LE`, `IF_ID_LE`, `pipe_LE`  out  1  load enables (`pipe_LE` gates ID_EX, EX_MEM, MEM_WB)
- `S`  out  1  CU_mux select; 1 = inject NOP control word into ID_EX
- `IF_ID_flush`  out  1  clear IF_ID on next edge
- `fwd_A`, `fwd_B`, `fwd_C`  out  2  operand selects for rn/rm/rd: 00 RF, 01 EX, 10 MEM, 11 WB
- `mem_err`  out  1  sticky memory-timeout flag
- `stall_count`  out  16  saturating count of stall cycles

## Operation
- States: FILL, RUN, MEM_WAIT, HALT. Control outputs are combinational (Mealy) from state and inputs; the state, `fill_cnt`, `wait_cnt`, `stall_count` and `mem_err` are registered.
- **FILL**
  - Outputs: `PC_LE=1`, `IF_ID_LE=1`, `pipe_LE=1`, `S=1`, `IF_ID_flush=0`.
  - `mem_ready` and all hazards are ignored.
  - Moves to RUN after `FILL_CYC` cycles.
- **RUN**, priority highest first:
  1. **Memory wait.** `MEM_Enable_signal && !mem_ready` → freeze: all three LEs 0, `S=0`, flush 0. Next state is MEM_WAIT with `wait_cnt=1`.
  2. **Load-use.** `EX_load_instr && EX_RF_enable && EX_rd` equals any used ID source → `PC_LE=0`, `IF_ID_LE=0`, `pipe_LE=1`, `S=1`, flush 0. This inserts exactly one bubble.
  3. **Branch.** `ID_branch_taken` → `IF_ID_flush=1`, all LEs 1, `S=0`.
  4. **Otherwise** all LEs 1, `S=0`, flush 0.
- **MEM_WAIT**
  - While `!mem_ready`: freeze and increment `wait_cnt`.
  - `wait_cnt==TIMEOUT` with `!mem_ready` → HALT.
  - `mem_ready=1` → RUN rules apply this cycle; next state RUN.
- **HALT**
  - All LEs 0, `S=1`, `mem_err=1`.
  - Held until `R`.
- **Forwarding**, per source, highest priority first:
  - EX, if `EX_RF_enable && !EX_load_instr` and indices match;
  - then MEM, if `MEM_RF_enable`;
  - then WB, if `WB_RF_enable`;
  - else 00.
  - Index 15 (PC) is never forwarded.
  - Forwarding is evaluated in every state.
- **stall_count** increments, saturating at 0xFFFF, on every cycle in RUN or MEM_WAIT where `PC_LE=0`.

## Timing
- Reset values:
  - state FILL, `fill_cnt=0`, `wait_cnt=0`, `stall_count=0`, `mem_err=0`.
  - Outputs as for FILL; `fwd_*` follow their inputs.
- Load-use costs exactly 1 cycle. The following cycle the load is in MEM, and the source forwards with `fwd=10`.
- Branch taken costs exactly 1 flushed slot.
- Simultaneous events:
  - Memory wait plus load-use: freeze only, no bubble. The load-use is re-evaluated after release.
  - Load-use plus branch: the stall wins and the flush is suppressed. The branch is re-evaluated next cycle.
- `R` asserted mid-operation → FILL immediately (asynchronous). Counters clear and `mem_err` clears.

## Structure
- Package `hazard_pkg` holds:
  - the state enum;
  - constants `FWD_RF=2'b00`, `FWD_EX=2'b01`, `FWD_MEM=2'b10`, `FWD_WB=2'b11`;
  - `PC_IDX=15`.
- Sub-module `fwd_select` handles one source index against EX/MEM/WB and outputs a 2-bit select. It is instantiated three times.

## Test plan
- Reset release → `S=1` for 4 cycles with `PC_LE=1`; 5th cycle `S=0`, state RUN.
- EX load to R3, ID reads R3 → 1 cycle `PC_LE=IF_ID_LE=0`, `S=1`; next cycle `fwd_A=10`; `stall_count=1`.
- EX ALU writes R2, MEM writes R2, ID reads R2 → `fwd_A=01`; ID reads R15 with EX writing R15 → `fwd_A=00`.
- `MEM_Enable_signal=1`, `mem_ready` low 3 cycles → `pipe_LE=0` for 3 cycles, `S=0`; resume on 4th; `stall_count=3`.
- `mem_ready` held low 20 cycles → HALT after 15 wait cycles, `mem_err=1`, `S=1`; assert `R` → `mem_err=0`, FILL.
- Load-use and `ID_branch_taken` same cycle → `IF_ID_flush=0`, bubble inserted; next cycle flush=1.
